// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end. It takes a fetch address from the
// CPU, serves it from an optional small cache, and otherwise issues a held
// request to the instruction ROM. A stalled ROM request raises a sticky
// fetchErr after MEM_LAT_MAX cycles.
// Optional feature: define IFETCH_CACHE_EN to build a 4-entry direct-mapped
// cache (index = addr[3:2], tag = addr[31:4]). Without it, every fetch goes to
// the ROM and flush has no effect.
module ifetch_unit #(
    parameter int MEM_LAT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcReq,
    input  logic        pcValid,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic        stall,
    output logic        fetchErr,
    output logic [31:0] memAddr,
    output logic        memReq,
    input  logic        memAck,
    input  logic [31:0] memData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter only has to reach MEM_LAT_MAX-1; keep it at least 1 bit wide.
    localparam int CNT_W = (MEM_LAT_MAX > 1) ? $clog2(MEM_LAT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_LAT_MAX > 0) ? MEM_LAT_MAX - 1 : 0);
    localparam bit TIMEOUT_EN = (MEM_LAT_MAX > 0);

    state_t            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              hit;
    logic [31:0]       hit_data;
    logic              timeout;

    // The address offset inside a word never matters to the fetch path.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pcReq[1:0];

    // Timeout fires on the last allowed MISS cycle only if the ROM stays silent;
    // an acknowledge arriving on that same edge still wins.
    assign timeout = TIMEOUT_EN && (state_q == MISS) && !memAck && (cnt_q == CNT_LAST);

`ifdef IFETCH_CACHE_EN
    logic [3:0]  valid_q, valid_d;
    logic [27:0] tag_mem  [4];
    logic [31:0] data_mem [4];
    logic [1:0]  lookup_idx;
    logic [1:0]  fill_idx;
    logic        fill_en;

    assign lookup_idx = pcReq[3:2];
    assign fill_idx   = mem_addr_q[3:2];
    assign fill_en    = (state_q == MISS) && memAck;

    // A flush in the lookup cycle forces a miss so stale lines are never used.
    assign hit      = valid_q[lookup_idx] && (tag_mem[lookup_idx] == pcReq[31:4]) && !flush;
    assign hit_data = data_mem[lookup_idx];

    // Valid bits: a fill sets its line, a simultaneous flush overrides everything.
    always_comb begin
        valid_d = valid_q;
        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Valid bits are the only cache state that needs resetting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage per line, written on a ROM fill.
    for (genvar gi = 0; gi < 4; gi++) begin : g_line
        always_ff @(posedge clk) begin
            if (fill_en && (fill_idx == 2'(gi))) begin
                tag_mem[gi]  <= mem_addr_q[31:4];
                data_mem[gi] <= memData;
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;

    logic unused_flush;
    assign unused_flush = flush;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pcValid) state_d = hit ? DONE : MISS;
            MISS:    if (memAck || timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: lookup result, ROM request handshake, timeout counter.
    always_comb begin
        instr_d     = instr_q;
        mem_addr_d  = mem_addr_q;
        mem_req_d   = mem_req_q;
        fetch_err_d = fetch_err_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (pcValid) begin
                    if (hit) begin
                        instr_d = hit_data;
                    end else begin
                        mem_addr_d = {pcReq[31:2], 2'b00};
                        mem_req_d  = 1'b1;
                        cnt_d      = '0;
                    end
                end
            end
            MISS: begin
                if (memAck) begin
                    instr_d   = memData;
                    mem_req_d = 1'b0;
                end else if (timeout) begin
                    instr_d     = '0;
                    mem_req_d   = 1'b0;
                    fetch_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset also drops an outstanding ROM request at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q     <= '0;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            fetch_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            instr_q     <= instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            fetch_err_q <= fetch_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Output decode: status strobes come straight from the state register.
    always_comb begin
        instrValid = (state_q == DONE);
        stall      = (state_q == MISS);
        instr      = instr_q;
        memAddr    = mem_addr_q;
        memReq     = mem_req_q;
        fetchErr   = fetch_err_q;
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed checks of ifetch_unit with MEM_LAT_MAX=3.
// Expectations follow the build: with IFETCH_CACHE_EN defined a repeated
// fetch hits, otherwise it goes back to the ROM.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcReq;
    logic        pcValid;
    logic        flush;
    logic [31:0] instr;
    logic        instrValid;
    logic        stall;
    logic        fetchErr;
    logic [31:0] memAddr;
    logic        memReq;
    logic        memAck;
    logic [31:0] memData;

    int checks = 0;
    int errors = 0;

    ifetch_unit #(.MEM_LAT_MAX(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .pcReq      (pcReq),
        .pcValid    (pcValid),
        .flush      (flush),
        .instr      (instr),
        .instrValid (instrValid),
        .stall      (stall),
        .fetchErr   (fetchErr),
        .memAddr    (memAddr),
        .memReq     (memReq),
        .memAck     (memAck),
        .memData    (memData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch address for one edge.
    task automatic do_req(input logic [31:0] addr);
        pcReq   = addr;
        pcValid = 1'b1;
        tick();
        pcValid = 1'b0;
    endtask

    // Acknowledge the ROM request with data for one edge.
    task automatic ack(input logic [31:0] data);
        memAck  = 1'b1;
        memData = data;
        tick();
        memAck  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pcReq = '0; pcValid = 1'b0; flush = 1'b0;
        memAck = 1'b0; memData = '0;
        tick();
        tick();
        check("rst_stall", stall, 0);
        check("rst_memReq", memReq, 0);
        check("rst_instrValid", instrValid, 0);
        check("rst_instr", instr, 0);
        check("rst_memAddr", memAddr, 0);
        check("rst_fetchErr", fetchErr, 0);
        reset = 1'b0;
        tick();

        // Basic miss: ROM answers two cycles after the request.
        do_req(32'h0000_0000);
        check("t1_memReq", memReq, 1);
        check("t1_memAddr", memAddr, 32'h0000_0000);
        check("t1_stall_c1", stall, 1);
        check("t1_iv_c1", instrValid, 0);
        tick();
        check("t1_stall_c2", stall, 1);
        check("t1_memReq_c2", memReq, 1);
        ack(32'h2008_0005);
        check("t1_iv", instrValid, 1);
        check("t1_instr", instr, 32'h2008_0005);
        check("t1_stall_done", stall, 0);
        check("t1_memReq_done", memReq, 0);
        tick();
        check("t1_iv_pulse", instrValid, 0);

        // Re-request the same address.
        do_req(32'h0000_0000);
`ifdef IFETCH_CACHE_EN
        check("t2_hit_memReq", memReq, 0);
        check("t2_hit_iv", instrValid, 1);
        check("t2_hit_instr", instr, 32'h2008_0005);
        tick();
`else
        check("t2_nocache_memReq", memReq, 1);
        ack(32'h2008_0005);
        check("t2_nocache_iv", instrValid, 1);
        tick();
`endif

        // Conflict: 0x4 and 0x14 share index 1.
        do_req(32'h0000_0004);
        check("t3_a_memReq", memReq, 1);
        check("t3_a_memAddr", memAddr, 32'h0000_0004);
        ack(32'h1111_1111);
        check("t3_a_instr", instr, 32'h1111_1111);
        tick();
        do_req(32'h0000_0014);
        check("t3_b_memReq", memReq, 1);
        check("t3_b_memAddr", memAddr, 32'h0000_0014);
        ack(32'h2222_2222);
        check("t3_b_instr", instr, 32'h2222_2222);
        tick();
        do_req(32'h0000_0004);
        check("t3_c_memReq", memReq, 1);
        ack(32'h1111_1111);
        check("t3_c_instr", instr, 32'h1111_1111);
        tick();

        // Flush on the fill edge; low address bits are ignored.
        do_req(32'h0000_000B);
        check("t4_memReq", memReq, 1);
        check("t4_memAddr", memAddr, 32'h0000_0008);
        flush = 1'b1;
        ack(32'h3333_3333);
        flush = 1'b0;
        check("t4_iv", instrValid, 1);
        check("t4_instr", instr, 32'h3333_3333);
        tick();
        do_req(32'h0000_0008);
        check("t4_refetch_memReq", memReq, 1);
        ack(32'h3333_3333);
        tick();
        // Line 2 is now filled; a flush in the lookup cycle must still miss.
        flush = 1'b1;
        do_req(32'h0000_0008);
        flush = 1'b0;
        check("t4_flush_lookup_memReq", memReq, 1);
        ack(32'h3333_3333);
        tick();

        // Timeout: no acknowledge for 3 MISS cycles.
        do_req(32'h0000_0040);
        check("t5_memReq", memReq, 1);
        tick();
        check("t5_stall_c2", stall, 1);
        check("t5_err_early", fetchErr, 0);
        tick();
        check("t5_stall_c3", stall, 1);
        tick();
        check("t5_fetchErr", fetchErr, 1);
        check("t5_memReq_drop", memReq, 0);
        check("t5_iv", instrValid, 1);
        check("t5_instr", instr, 32'h0000_0000);
        tick();
        check("t5_err_sticky", fetchErr, 1);
        check("t5_iv_pulse", instrValid, 0);

        // Reset in the middle of a miss, acknowledge arrives afterwards.
        do_req(32'h0000_0050);
        check("t6_memReq", memReq, 1);
        reset = 1'b1;
        #1;
        check("t6_rst_memReq", memReq, 0);
        check("t6_rst_stall", stall, 0);
        check("t6_rst_fetchErr", fetchErr, 0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        memAck  = 1'b1;
        memData = 32'h4444_4444;
        tick();
        memAck = 1'b0;
        check("t6_late_ack_iv", instrValid, 0);
        check("t6_late_ack_memReq", memReq, 0);
        check("t6_late_ack_stall", stall, 0);
        check("t6_late_ack_instr", instr, 32'h0000_0000);
        tick();
        check("t6_iv_after", instrValid, 0);
        // Back in IDLE: a fresh request is accepted.
        do_req(32'h0000_0050);
        check("t6_idle_memReq", memReq, 1);
        check("t6_idle_memAddr", memAddr, 32'h0000_0050);
        ack(32'h5555_5555);
        check("t6_idle_instr", instr, 32'h5555_5555);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter MEM_LAT_MAX, default 15, meaning maximum MISS cycles before a timeout error; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port pcReq, input, 32 bits: fetch address from the CPU (nextInstrAddress).
REQ-005 SHALL have port pcValid, input, 1 bit: pcReq is valid this cycle.
REQ-006 SHALL have port flush, input, 1 bit: invalidate all cache lines.
REQ-007 SHALL have port instr, output, 32 bits: fetched instruction word.
REQ-008 SHALL have port instrValid, output, 1 bit: one-cycle pulse; instr is valid.
REQ-009 SHALL have port stall, output, 1 bit: high while a miss is outstanding.
REQ-010 SHALL have port fetchErr, output, 1 bit: sticky timeout flag.
REQ-011 SHALL have port memAddr, output, 32 bits: word-aligned instruction-ROM address.
REQ-012 SHALL have port memReq, output, 1 bit: ROM request, held until acknowledged.
REQ-013 SHALL have port memAck, input, 1 bit: ROM acknowledge; memData is valid in the same cycle.
REQ-014 SHALL have port memData, input, 32 bits: ROM read data.

Function
REQ-015 SHALL implement the states IDLE, MISS and DONE, all held in registers.
REQ-016 In IDLE with pcValid=1 and a cache hit, SHALL load instr from the cache and go to DONE; instrValid is high the next cycle (latency 1).
REQ-017 In IDLE with pcValid=1 and a miss, SHALL register memAddr={pcReq[31:2],2'b00}, set memReq=1 and go to MISS.
REQ-018 In MISS, SHALL hold memReq=1 and memAddr stable until memAck=1 is sampled; SHALL then capture memData into instr, fill the cache line, clear memReq and go to DONE.
REQ-019 In DONE, SHALL hold instrValid=1 for exactly one cycle, then return to IDLE.
REQ-020 Miss latency SHALL be: pcValid sampled at cycle N, memAck at cycle N+k (k>=1), instrValid at cycle N+k+1.
REQ-021 stall SHALL equal (state==MISS).
REQ-022 pcValid SHALL be ignored in MISS and DONE; memAck SHALL be ignored in IDLE and DONE.
REQ-023 pcReq[1:0] SHALL be ignored.
REQ-024 flush SHALL clear every valid bit at the next edge.
REQ-025 If flush coincides with a fill, flush SHALL win (line left invalid); the in-flight instr SHALL still be delivered.
REQ-026 If flush is high in the same cycle as an IDLE lookup, that lookup SHALL be treated as a miss.
REQ-027 If MEM_LAT_MAX>0 and MISS lasts MEM_LAT_MAX cycles without memAck, SHALL set fetchErr=1, drop memReq, deliver instr=32'h0000_0000 with instrValid, and go to DONE.
REQ-028 fetchErr SHALL be cleared only by reset.

Reset
REQ-029 On reset assertion, SHALL immediately set state=IDLE, instr=0, instrValid=0, memReq=0, memAddr=0, fetchErr=0 and all valid bits=0, and clear the miss counter.
REQ-030 Reset during MISS SHALL drop memReq asynchronously, and a later memAck SHALL be ignored.
REQ-031 stall SHALL be 0 while reset is asserted.

Configuration
REQ-032 With IFETCH_CACHE_EN defined, SHALL implement a 4-entry direct-mapped cache: index = addr[3:2], tag = addr[31:4], one valid bit per line.
REQ-033 Without IFETCH_CACHE_EN, every request SHALL miss, no cache storage is built, and flush has no effect.

Verification
REQ-034 Bench SHALL check: reset, then pcValid with pcReq=0x0000_0000 and memAck 2 cycles after memReq with memData=0x2008_0005 -> stall high for 2 cycles, then instrValid with instr=0x2008_0005.
REQ-035 Bench SHALL check, with the cache enabled: re-request 0x0000_0000 -> memReq stays 0 and instrValid comes 1 cycle later with 0x2008_0005; with the cache disabled the same stimulus -> memReq=1.
REQ-036 Bench SHALL check a conflict: fetch 0x0000_0004, then 0x0000_0014 (same index) -> both miss; refetch 0x0000_0004 -> miss.
REQ-037 Bench SHALL check: flush asserted on the cycle memAck returns for 0x0000_0008 -> instr delivered; refetch 0x0000_0008 -> memReq=1.
REQ-038 Bench SHALL check, with MEM_LAT_MAX=3: no memAck -> after 3 MISS cycles fetchErr=1, memReq=0, instrValid with instr=0.
REQ-039 Bench SHALL check: reset pulsed mid-MISS with memAck arriving afterwards -> memReq=0, no instrValid, state IDLE.
